// File: rtl/smg_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit per slot on a shared active-low segment bus.
// Latency: outputs registered, one clock behind the slot/digit counters; input snapshot taken once per frame.
// No backpressure; en=0 darks the display and freezes all counters. Optional LZ_BLANK_EN adds leading-zero blanking.
module smg_scan_driver #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 33,
  parameter int BLINK_DIV = 16384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   Number_Data,
  input  logic [DIGITS/2-1:0]   Blink,
  input  logic [DIGITS-1:0]     Dp_Mask,
  output logic [7:0]            Row_Scan_Sig,
  output logic [DIGITS-1:0]     Column_Scan_Sig
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0]         p;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         bc;
  logic                  blink_ph;
  logic [4*DIGITS-1:0]   sh_num;
  logic [DIGITS/2-1:0]   sh_blink;
  logic [DIGITS-1:0]     sh_dp;

  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic                  cur_blink;
  logic [7:0]            cur_glyph;
  logic [7:0]            row_next;
  logic [DIGITS-1:0]     col_next;

  // Active-low segment pattern for a BCD digit, dp off; non-decimal codes are dark.
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

`ifdef LZ_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  logic              lz_run;
  logic              cur_lz;

  // Mark digits from the top down that are zero up to the first nonzero; digit 0 always shown.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (sh_num[4*i +: 4] == 4'd0);
      lz_mask[i] = lz_run;
    end
  end
`endif

  // Pick the snapshot fields of the digit currently being scanned and build the select pattern.
  always_comb begin
    cur_val   = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    col_next  = '1;
`ifdef LZ_BLANK_EN
    cur_lz    = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_val     = sh_num[4*i +: 4];
        cur_dp      = sh_dp[i];
        cur_blink   = sh_blink[i/2];
        col_next[i] = 1'b0;
`ifdef LZ_BLANK_EN
        cur_lz      = lz_mask[i];
`endif
      end
    end
  end

  // Segment pattern: blank on the first clock of each slot (ghost guard) and during the blink-off phase.
  always_comb begin
    cur_glyph = glyph(cur_val);
    row_next  = 8'hFF;
    if ((p != '0) && !(blink_ph && cur_blink)) begin
      row_next = {~cur_dp, cur_glyph[6:0]};
`ifdef LZ_BLANK_EN
      if (cur_lz) row_next[6:0] = 7'h7F;
`endif
    end
  end

  // Slot/digit/blink counters, frame snapshot and registered outputs; everything holds while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p               <= '0;
      idx             <= '0;
      bc              <= '0;
      blink_ph        <= 1'b0;
      sh_num          <= '0;
      sh_blink        <= '0;
      sh_dp           <= '0;
      Row_Scan_Sig    <= 8'hFF;
      Column_Scan_Sig <= '1;
    end else if (en) begin
      if (p == P_LAST) begin
        p   <= '0;
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
      if (bc == B_LAST) begin
        bc       <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        bc <= bc + 1'b1;
      end
      if ((p == '0) && (idx == '0)) begin
        sh_num   <= Number_Data;
        sh_blink <= Blink;
        sh_dp    <= Dp_Mask;
      end
      Row_Scan_Sig    <= row_next;
      Column_Scan_Sig <= col_next;
    end else begin
      Row_Scan_Sig    <= 8'hFF;
      Column_Scan_Sig <= '1;
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Bench for the scan driver with DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
// Reference model tracks only the count of enabled clocks since reset and derives slot, digit
// and blink phase arithmetically from it, plus a frame snapshot of the inputs.
module tb_smg_scan_driver;
  localparam int DG = 4;
  localparam int SD = 4;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   Number_Data = '0;
  logic [1:0]    Blink = '0;
  logic [3:0]    Dp_Mask = '0;
  logic [7:0]    Row_Scan_Sig;
  logic [3:0]    Column_Scan_Sig;

  smg_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Number_Data(Number_Data), .Blink(Blink),
    .Dp_Mask(Dp_Mask), .Row_Scan_Sig(Row_Scan_Sig), .Column_Scan_Sig(Column_Scan_Sig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: enabled clocks since reset, and the frame snapshot.
  int          n = 0;
  logic [15:0] sh_num = '0;
  logic [1:0]  sh_blink = '0;
  logic [3:0]  sh_dp = '0;

  logic [7:0] glyph_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic check(input string tag, input logic [7:0] row_e, input logic [3:0] col_e);
    checks++;
    assert (Row_Scan_Sig === row_e) passes++;
    else $error("FAIL %s row: got %h want %h (n=%0d)", tag, Row_Scan_Sig, row_e, n);
    checks++;
    assert (Column_Scan_Sig === col_e) passes++;
    else $error("FAIL %s col: got %h want %h (n=%0d)", tag, Column_Scan_Sig, col_e, n);
  endtask

  // One clock: predict from pre-edge state and inputs, clock, then compare.
  task automatic tick(input string tag);
    logic [7:0] er;
    logic [3:0] ec;
    int p, d, ph, v;
    er = 8'hFF;
    ec = 4'hF;
    if (rst_n && en) begin
      p  = n % SD;
      d  = (n / SD) % DG;
      ph = (n / BD) % 2;
      ec = 4'hF;
      ec[d] = 1'b0;
      if (p != 0 && !(ph == 1 && sh_blink[d/2])) begin
        v  = int'((sh_num >> (4*d)) & 16'hF);
        er = glyph_tab[v];
`ifdef LZ_BLANK_EN
        if (d > 0 && (sh_num >> (4*d)) == 16'h0) er = 8'hFF;
`endif
        er[7] = ~sh_dp[d];
      end
      if (p == 0 && d == 0) begin
        sh_num   = Number_Data;
        sh_blink = Blink;
        sh_dp    = Dp_Mask;
      end
      n++;
    end
    @(posedge clk);
    #1;
    check(tag, er, ec);
  endtask

  task automatic model_reset();
    n = 0;
    sh_num = '0;
    sh_blink = '0;
    sh_dp = '0;
  endtask

  initial begin
    // Reset held: inputs wiggle, outputs must stay dark.
    for (int i = 0; i < 4; i++) begin
      en = 1'(i % 2);
      Number_Data = 16'($urandom);
      Blink = 2'($urandom);
      Dp_Mask = 4'($urandom);
      tick("reset_hold");
    end

    // Release and scan 16'h1234 for two frames.
    @(negedge clk);
    Number_Data = 16'h1234;
    Blink = 2'b00;
    Dp_Mask = 4'b0000;
    en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 2*DG*SD; i++) tick("scan_1234");

    // Coherency: change data while digit 2 is being scanned.
    while ((n % (DG*SD)) != 2*SD + 1) tick("coh_align");
    Number_Data = 16'h5678;
    for (int i = 0; i < 24; i++) tick("coherency");

    // Blink on field 1 (digits 2,3).
    Blink = 2'b10;
    for (int i = 0; i < 2*DG*SD; i++) tick("blink");
    Blink = 2'b00;

    // Decimal point on digit 0 and a non-decimal code on digit 2.
    Dp_Mask = 4'b0001;
    Number_Data = 16'h3A94;
    for (int i = 0; i < 2*DG*SD; i++) tick("dp_invalid");

    // Enable low: dark, counters hold, then resume.
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick("en_off");
    en = 1'b1;
    for (int i = 0; i < DG*SD; i++) tick("en_resume");

    // Asynchronous reset mid-slot: takes effect without a clock edge.
    while ((n % SD) != 2) tick("rst_align");
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'hFF, 4'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Leading-zero patterns (plain glyphs when the option is absent).
    Dp_Mask = 4'b0000;
    Number_Data = 16'h0040;
    for (int i = 0; i < 2*DG*SD; i++) tick("lz_0040");
    Number_Data = 16'h0000;
    for (int i = 0; i < 2*DG*SD; i++) tick("lz_0000");

    // Randomized run: mostly-enabled, random data/blink/dp, occasional BCD-only data.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0)
          Number_Data = 16'($urandom);
        else
          Number_Data = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        Blink = 2'($urandom);
        Dp_Mask = 4'($urandom);
      end
      tick("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
